// File: rtl/clock_meas_pkg.sv
// Shared types and register map for the clock-counter poller.
package clock_meas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ID,
      ST_WT_ID,
      ST_RD_CH,
      ST_WT_CH,
      ST_EMIT
   } state_t;

   localparam logic [31:0] CLKCNT_ID   = 32'hc10cc272;

   localparam logic [3:0]  REG_ID      = 4'd0;
   localparam logic [3:0]  REG_VERSION = 4'd1;
   localparam logic [3:0]  REG_SCRATCH = 4'd3;
   localparam logic [3:0]  REG_MEAS0   = 4'd4;

   localparam int          NUM_CH_MAX  = 8;

   // Inclusive unsigned window test.
   function automatic logic in_window(input logic [31:0] v,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/clock_meas_poller_timer.sv
// Scan period timer: raises one pending tick per period and flags ticks that
// arrive while the previous one is still queued or a scan is running.
module poll_timer #(
   parameter int POLL_CYCLES = 125000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   input  logic tick_take,
   output logic tick_pending,
   output logic overrun
);

   localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam logic [TW-1:0] LAST = TW'(POLL_CYCLES - 1);

   logic [TW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == LAST);

   // Free-running period counter, 0..POLL_CYCLES-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (wrap) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

   // A new tick wins over a same-cycle take so it is never lost; ticks collapse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_pending <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (wrap)           tick_pending <= 1'b1;
         else if (tick_take) tick_pending <= 1'b0;
         if (wrap && (tick_pending || busy)) overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/clock_meas_poller.sv
// Avalon-MM poller: reads the clock counter ID and each frequency register,
// checks every value against a window and streams it out on Avalon-ST.
module clock_meas_poller
   import clock_meas_pkg::*;
#(
   parameter int          POLL_CYCLES = 125000000,
   parameter int          NUM_CH      = 8,
   parameter logic [3:0]  ADDR_ID     = REG_ID,
   parameter logic [3:0]  ADDR_MEAS0  = REG_MEAS0,
   parameter logic [31:0] EXP_ID      = CLKCNT_ID,
   parameter logic [31:0] FREQ_LO     = 32'd124000000,
   parameter logic [31:0] FREQ_HI     = 32'd126000000,
   parameter int          TIMEOUT     = 255
) (
   input  logic        csi_clk_clk,
   input  logic        rsi_reset_reset_n,
   output logic [3:0]  avm_meas_address,
   output logic        avm_meas_read,
   input  logic        avm_meas_waitrequest,
   input  logic [31:0] avm_meas_readdata,
   input  logic        avm_meas_readdatavalid,
   output logic [31:0] aso_meas_data,
   output logic [2:0]  aso_meas_channel,
   output logic        aso_meas_valid,
   input  logic        aso_meas_ready,
   output logic        coe_id_ok,
   output logic [7:0]  coe_freq_ok,
   output logic        coe_err_timeout,
   output logic        coe_overrun
);

   localparam int         TCW     = $clog2(TIMEOUT + 1);
   localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);
   localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
   localparam logic [7:0] CH_MASK = 8'((1 << NUM_CH) - 1);

   state_t         state, state_nxt;
   logic [2:0]     ch;
   logic [TCW-1:0] tcnt;
   logic [31:0]    data;
   logic           id_ok;
   logic [7:0]     freq_ok;
   logic           err_timeout;

   logic           tick_pending, tick_take, accept, got, tmo, rd;
   logic [3:0]     addr;

   poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_timer (
      .clk          (csi_clk_clk),
      .rst_n        (rsi_reset_reset_n),
      .busy         (state != ST_IDLE),
      .tick_take    (tick_take),
      .tick_pending (tick_pending),
      .overrun      (coe_overrun)
   );

   // State register.
   always_ff @(posedge csi_clk_clk or negedge rsi_reset_reset_n) begin
      if (!rsi_reset_reset_n) state <= ST_IDLE;
      else                    state <= state_nxt;
   end

   // Next state plus bus strobes; read/address derive from state so they
   // stay stable through waitrequest and drop the cycle after acceptance.
   always_comb begin
      state_nxt = state;
      tick_take = 1'b0;
      accept    = 1'b0;
      got       = 1'b0;
      tmo       = 1'b0;
      rd        = 1'b0;
      addr      = 4'd0;
      case (state)
         ST_IDLE: if (tick_pending) begin
            tick_take = 1'b1;
            state_nxt = ST_RD_ID;
         end
         ST_RD_ID: begin
            rd   = 1'b1;
            addr = ADDR_ID;
            if (!avm_meas_waitrequest) begin
               accept    = 1'b1;
               state_nxt = ST_WT_ID;
            end
         end
         ST_WT_ID: begin
            if (avm_meas_readdatavalid) begin
               got       = 1'b1;
               state_nxt = (avm_meas_readdata == EXP_ID) ? ST_RD_CH : ST_IDLE;
            end else if (tcnt == TO_LAST) begin
               tmo       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_RD_CH: begin
            rd   = 1'b1;
            addr = 4'(ADDR_MEAS0 + 4'(ch));
            if (!avm_meas_waitrequest) begin
               accept    = 1'b1;
               state_nxt = ST_WT_CH;
            end
         end
         ST_WT_CH: begin
            if (avm_meas_readdatavalid) begin
               got       = 1'b1;
               state_nxt = ST_EMIT;
            end else if (tcnt == TO_LAST) begin
               tmo       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_EMIT: if (aso_meas_ready)
            state_nxt = (ch == LAST_CH) ? ST_IDLE : ST_RD_CH;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: wait timer, channel index, captured data and status flags.
   always_ff @(posedge csi_clk_clk or negedge rsi_reset_reset_n) begin
      if (!rsi_reset_reset_n) begin
         tcnt        <= '0;
         ch          <= 3'd0;
         data        <= 32'd0;
         id_ok       <= 1'b0;
         freq_ok     <= 8'd0;
         err_timeout <= 1'b0;
      end else begin
         if (accept)                                          tcnt <= '0;
         else if (state == ST_WT_ID || state == ST_WT_CH)     tcnt <= tcnt + 1'b1;
         if (tmo) begin
            err_timeout <= 1'b1;
            id_ok       <= 1'b0;
         end
         if (got && state == ST_WT_ID) begin
            id_ok <= (avm_meas_readdata == EXP_ID);
            if (avm_meas_readdata == EXP_ID) ch      <= 3'd0;
            else                             freq_ok <= 8'd0;
         end
         if (got && state == ST_WT_CH) begin
            data        <= avm_meas_readdata;
            freq_ok[ch] <= in_window(avm_meas_readdata, FREQ_LO, FREQ_HI);
         end
         if (state == ST_EMIT && aso_meas_ready && ch != LAST_CH) ch <= ch + 3'd1;
      end
   end

   assign avm_meas_address = addr;
   assign avm_meas_read    = rd;
   assign aso_meas_data    = data;
   assign aso_meas_channel = ch;
   assign aso_meas_valid   = (state == ST_EMIT);
   assign coe_id_ok        = id_ok;
   assign coe_freq_ok      = freq_ok & CH_MASK;
   assign coe_err_timeout  = err_timeout;

endmodule

// File: tb/tb_clock_meas_poller.sv
// Randomized bench for clock_meas_poller with a behavioural slave and ST sink.
module tb_clock_meas_poller;
   import clock_meas_pkg::*;

   localparam int POLL = 100;
   localparam int NCH  = 8;
   localparam int TMO  = 16;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [3:0]  address;
   logic        read, waitreq = 1'b0, rdv = 1'b0, valid, ready = 1'b1;
   logic [31:0] rdata = 32'd0, st_data;
   logic [2:0]  st_ch;
   logic        id_ok, err_tmo, ovr;
   logic [7:0]  freq_ok;

   clock_meas_poller #(.POLL_CYCLES(POLL), .NUM_CH(NCH), .TIMEOUT(TMO)) dut (
      .csi_clk_clk(clk), .rsi_reset_reset_n(rst_n),
      .avm_meas_address(address), .avm_meas_read(read),
      .avm_meas_waitrequest(waitreq), .avm_meas_readdata(rdata),
      .avm_meas_readdatavalid(rdv),
      .aso_meas_data(st_data), .aso_meas_channel(st_ch),
      .aso_meas_valid(valid), .aso_meas_ready(ready),
      .coe_id_ok(id_ok), .coe_freq_ok(freq_ok),
      .coe_err_timeout(err_tmo), .coe_overrun(ovr));

   always #5 clk = ~clk;

   int nvec = 0, nerr = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference rule for the frequency window.
   function automatic logic win(input logic [31:0] v);
      return (v >= 32'd124000000) && (v <= 32'd126000000);
   endfunction

   // ---------------- slave model ----------------
   int          lat = 1, waits = 0, hold_ch = 0;
   bit          spur_en = 1'b0, hold_en = 1'b0;
   logic [31:0] id_val = 32'hc10cc272;
   logic [31:0] meas [8];
   int          due = 0, stall = 0, acc_cnt = 0, scan_cnt = 0;
   int          last_scan = 0, prev_scan = 0, hold_acc = 0;
   bit          chk_drop = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
   logic [3:0]  prev_addr = 4'd0;
   logic [31:0] resp = 32'd0;

   function automatic logic [31:0] reg_val(input logic [3:0] a);
      if (a == 4'd0) return id_val;
      if (a >= 4'd4 && a < 4'd12) return meas[a - 4'd4];
      return 32'd0;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         due = 0; stall = 0; chk_drop = 0; prev_rd = 0; prev_wr = 0;
         rdv = 0; waitreq = 0;
      end else begin
         if (prev_rd && prev_wr)
            chk("stall_hold", {read, address}, {1'b1, prev_addr});
         if (chk_drop) begin
            chk("rd_drop", read, 1'b0);
            chk_drop = 0;
         end
         rdv = 0;
         if (due > 0) begin
            due--;
            if (due == 0) begin rdv = 1; rdata = resp; end
         end else if (spur_en && !hold_en && !read && $urandom_range(0, 7) == 0) begin
            rdv = 1; rdata = $urandom;
         end
         if (read && !prev_rd && address == 4'd0) begin
            scan_cnt++; prev_scan = last_scan; last_scan = cyc;
         end
         prev_rd = read; prev_addr = address;
         if (read) begin
            if (stall < waits) begin
               waitreq = 1; stall++;
            end else begin
               waitreq = 0; stall = 0;
               chk("one_outst", due, 0);
               acc_cnt++; chk_drop = 1;
               resp = reg_val(address);
               if (hold_en && address == 4'(4 + hold_ch)) begin
                  due = 0; hold_acc = cyc + 1;
               end else due = lat;
            end
         end else begin
            waitreq = 0; stall = 0;
         end
         prev_wr = waitreq;
      end
   end

   // ---------------- ST sink / status monitor ----------------
   int          bch[$];
   logic [31:0] bdat[$];
   bit          pv = 0, pr = 0, perr = 0;
   logic [31:0] pdata = 0;
   logic [2:0]  pch = 0;
   int          err_cyc = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 0; pr = 0; perr = 0;
      end else begin
         if (pv && !pr) chk("st_hold", {valid, st_ch, st_data}, {1'b1, pch, pdata});
         if (valid && ready) begin bch.push_back(int'(st_ch)); bdat.push_back(st_data); end
         if (err_tmo && !perr) err_cyc = cyc;
         pv = valid; pr = ready; pdata = st_data; pch = st_ch; perr = err_tmo;
      end
   end

   // ---------------- scenario helpers ----------------
   logic [7:0] exp_fok = 8'd0;
   int         acc0 = 0;

   task automatic run_scan(input int window);
      int s0, n;
      bch.delete(); bdat.delete();
      acc0 = acc_cnt; s0 = scan_cnt; n = 0;
      while (scan_cnt == s0 && n < 400) begin @(posedge clk); n++; end
      if (scan_cnt == s0) chk("scan_start", 0, 1);
      repeat (window) @(posedge clk);
      #1;
   endtask

   task automatic check_full(input string tag);
      for (int i = 0; i < NCH; i++) exp_fok[i] = win(meas[i]);
      chk({tag, "_beats"}, bch.size(), NCH);
      chk({tag, "_reads"}, acc_cnt - acc0, NCH + 1);
      for (int i = 0; i < NCH && i < bch.size(); i++) begin
         chk({tag, "_ch"}, bch[i], i);
         chk({tag, "_data"}, bdat[i], meas[i]);
      end
      chk({tag, "_id_ok"}, id_ok, 1'b1);
      chk({tag, "_freq_ok"}, freq_ok, exp_fok);
   endtask

   task automatic nominal();
      for (int i = 0; i < NCH; i++) meas[i] = 32'(125000000 + i * 1000);
      id_val = 32'hc10cc272;
   endtask

   function automatic logic [31:0] rnd_meas();
      logic [31:0] edges [4];
      edges[0] = 32'd123999999; edges[1] = 32'd124000000;
      edges[2] = 32'd126000000; edges[3] = 32'd126000001;
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'd124000000 + $urandom_range(0, 2000000);
         2:       return edges[$urandom_range(0, 3)];
         default: return 32'd123000000 + $urandom_range(0, 4000000);
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int s1, n;
      nominal();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_read", read, 0);        chk("rst_addr", address, 0);
      chk("rst_valid", valid, 0);      chk("rst_data", st_data, 0);
      chk("rst_ch", st_ch, 0);         chk("rst_id_ok", id_ok, 0);
      chk("rst_freq_ok", freq_ok, 0);  chk("rst_err", err_tmo, 0);
      chk("rst_ovr", ovr, 0);
      rst_n = 1'b1;

      // nominal values, latency 1, stray readdatavalid pulses while idle
      spur_en = 1;
      run_scan(90);
      check_full("s1");
      chk("s1_fok_ff", freq_ok, 8'hff);
      run_scan(90);
      check_full("s1b");
      chk("s1_period", last_scan - prev_scan, POLL);

      // window boundaries
      meas[3] = 32'd123999999; meas[5] = 32'd126000001; meas[6] = 32'd126000000;
      run_scan(90);
      check_full("s2");
      chk("s2_fok", freq_ok, 8'b1101_0111);

      // ID mismatch
      id_val = 32'hdeadbeef;
      run_scan(90);
      chk("s3_reads", acc_cnt - acc0, 1);
      chk("s3_beats", bch.size(), 0);
      chk("s3_id_ok", id_ok, 0);
      chk("s3_freq_ok", freq_ok, 0);
      exp_fok = 8'd0;

      // waitrequest stalls and longer latency
      nominal(); waits = 5; lat = 3;
      run_scan(95);
      check_full("s4");

      // randomized values and slave timing
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NCH; i++) meas[i] = rnd_meas();
         waits = $urandom_range(0, 3); lat = $urandom_range(1, 3);
         run_scan(90);
         check_full("rnd");
      end

      // timeout on channel 2
      waits = 0; lat = 1;
      for (int i = 0; i < NCH; i++) meas[i] = rnd_meas();
      hold_en = 1; hold_ch = 2;
      run_scan(90);
      for (int i = 0; i < 2; i++) exp_fok[i] = win(meas[i]);
      chk("s5_err", err_tmo, 1);
      chk("s5_id_ok", id_ok, 0);
      chk("s5_beats", bch.size(), 2);
      chk("s5_reads", acc_cnt - acc0, 4);
      chk("s5_freq_ok", freq_ok, exp_fok);
      chk("s5_tmo_time", err_cyc - hold_acc, TMO);
      hold_en = 0;
      run_scan(90);
      check_full("s5b");
      chk("s5b_err_sticky", err_tmo, 1);
      chk("ovr_clear", ovr, 0);

      // ST backpressure across two poll periods
      nominal();
      ready = 1'b0;
      run_scan(0);
      s1 = scan_cnt;
      repeat (250) @(posedge clk);
      #1;
      chk("s6_ovr", ovr, 1);
      chk("s6_stalled", scan_cnt - s1, 0);
      chk("s6_no_beats", bch.size(), 0);
      ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("s6_extra_scan", scan_cnt - s1, 1);

      // reset while a beat is waiting
      ready = 1'b0;
      n = 0;
      while (!valid && n < 400) begin @(posedge clk); n++; end
      chk("s7_reach_emit", valid, 1);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("s7_valid", valid, 0);   chk("s7_read", read, 0);
      chk("s7_ovr", ovr, 0);       chk("s7_err", err_tmo, 0);
      chk("s7_id_ok", id_ok, 0);   chk("s7_freq_ok", freq_ok, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; ready = 1'b1;
      run_scan(90);
      check_full("s7b");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
